hs_rx_unpacker: RTL and testbench



---
 rtl/hs_rx_pkg.sv | 17 +
 rtl/hs_rx_slicer.sv | 39 +++
 rtl/hs_rx_unpacker.sv | 98 +++++++++
 tb/tb_hs_rx_unpacker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_rx_pkg.sv
// rtl/hs_rx_pkg.sv - shared state encoding, default widths and index-width helper for hs_rx_unpacker
package hs_rx_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_OUT_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT     = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   function automatic int idx_w(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/hs_rx_slicer.sv
// rtl/hs_rx_slicer.sv - word shift register and slice index, MSB slice presented first
module hs_rx_slicer
   import hs_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   output logic [OUT_W-1:0] slice,
   output logic             last
);

   localparam int NSLICE = WIDTH / OUT_W;
   localparam int IW     = idx_w(NSLICE);

   logic [WIDTH-1:0] shreg;
   logic [IW-1:0]    idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg <= '0;
         idx   <= '0;
      end else if (load) begin
         shreg <= load_data;
         idx   <= '0;
      end else if (shift) begin
         shreg <= shreg << OUT_W;
         idx   <= idx + 1'b1;
      end
   end

   assign slice = shreg[WIDTH-1 -: OUT_W];
   assign last  = (idx == IW'(NSLICE - 1));

endmodule

// File: rtl/hs_rx_unpacker.sv
// rtl/hs_rx_unpacker.sv - splits synchronizer words into FIFO-width slices; HS_RX_UNPACKER_WCNT_EN adds word_cnt
module hs_rx_unpacker
   import hs_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy,
   input  logic             fifo_full,
   output logic             fifo_winc,
   output logic [OUT_W-1:0] fifo_wdata,
   output logic             overrun
`ifdef HS_RX_UNPACKER_WCNT_EN
   ,
   output logic [15:0]      word_cnt
`endif
);

   if (WIDTH % OUT_W != 0) begin : g_width_check
      $error("hs_rx_unpacker: WIDTH must be a multiple of OUT_W");
   end

   state_t           state, state_nx;
   logic             in_valid_d;
   logic             rise;
   logic             load;
   logic             last;
   logic [OUT_W-1:0] slice;

   assign rise = in_valid & ~in_valid_d;

   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      fifo_winc = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               load     = 1'b1;
               state_nx = EMIT;
            end
         end
         EMIT: begin
            fifo_winc = ~fifo_full;
            if (fifo_winc && last) state_nx = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!in_valid) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fifo_wdata = (state == EMIT) ? slice : '0;

   // in_valid_d resets high so a level already high at reset release is not a new word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_valid_d <= 1'b1;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nx;
         in_valid_d <= in_valid;
         busy       <= (state_nx != IDLE);
         if (rise && state != IDLE) overrun <= 1'b1;
      end
   end

   hs_rx_slicer #(
      .WIDTH (WIDTH),
      .OUT_W (OUT_W)
   ) u_slicer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (in_data),
      .shift     (fifo_winc),
      .slice     (slice),
      .last      (last)
   );

`ifdef HS_RX_UNPACKER_WCNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (fifo_winc && last) begin
         word_cnt <= word_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hs_rx_unpacker.sv
// tb/tb_hs_rx_unpacker.sv - self-checking bench for hs_rx_unpacker: vector tables, corner sequences, random vs queue model
module tb_hs_rx_unpacker;

   localparam int WIDTH  = 32;
   localparam int OUT_W  = 8;
   localparam int NSLICE = WIDTH / OUT_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             busy;
   logic             fifo_full;
   logic             fifo_winc;
   logic [OUT_W-1:0] fifo_wdata;
   logic             overrun;
`ifdef HS_RX_UNPACKER_WCNT_EN
   logic [15:0]      word_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hs_rx_unpacker #(
      .WIDTH (WIDTH),
      .OUT_W (OUT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_winc  (fifo_winc),
      .fifo_wdata (fifo_wdata),
      .overrun    (overrun)
`ifdef HS_RX_UNPACKER_WCNT_EN
      ,
      .word_cnt   (word_cnt)
`endif
   );

   // reference model: pending slices of the word in flight, plus the wait-for-low phase
   logic [OUT_W-1:0] m_q[$];
   bit               m_wait, m_prev, m_busy, m_ov;
   logic [15:0]      m_cnt;
   logic [OUT_W-1:0] wlog[$];

   typedef struct {
      bit               iv;
      logic [WIDTH-1:0] d;
      bit               f;
      bit               ew;
      logic [OUT_W-1:0] ewd;
      bit               eb;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_wait = 1'b0;
      m_prev = 1'b1;
      m_busy = 1'b0;
      m_ov   = 1'b0;
      m_cnt  = '0;
   endtask

   task automatic drive(input bit r, input bit iv, input logic [WIDTH-1:0] d, input bit f);
      rst_n     = r;
      in_valid  = iv;
      in_data   = d;
      fifo_full = f;
      #3;
      check("winc", fifo_winc, (m_q.size() > 0) && !f);
      check("busy", busy, m_busy);
      check("overrun", overrun, m_ov);
      if (m_q.size() > 0) check("wdata", fifo_wdata, m_q[0]);
`ifdef HS_RX_UNPACKER_WCNT_EN
      check("word_cnt", word_cnt, m_cnt);
`endif
      if (fifo_winc && r) wlog.push_back(fifo_wdata);
   endtask

   task automatic tick();
      bit               r  = rst_n;
      bit               iv = in_valid;
      bit               f  = fifo_full;
      logic [WIDTH-1:0] d  = in_data;
      bit               rise, active;
      @(posedge clk);
      if (!r) begin
         model_reset();
      end else begin
         rise   = iv && !m_prev;
         active = (m_q.size() > 0) || m_wait;
         if (m_wait && !iv) m_wait = 1'b0;
         if (m_q.size() > 0 && !f) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_wait = 1'b1;
               m_cnt++;
            end
         end
         if (rise) begin
            if (active) m_ov = 1'b1;
            else for (int k = NSLICE - 1; k >= 0; k--) m_q.push_back(d[k*OUT_W +: OUT_W]);
         end
         m_prev = iv;
         m_busy = (m_q.size() > 0) || m_wait;
      end
      #1;
   endtask

   task automatic cyc(input bit r, input bit iv, input logic [WIDTH-1:0] d, input bit f);
      drive(r, iv, d, f);
      tick();
   endtask

   task automatic check_log(input string nm, input logic [WIDTH-1:0] word);
      logic [WIDTH-1:0] w = word;
      check({nm, "_count"}, wlog.size(), NSLICE);
      for (int k = 0; k < NSLICE; k++)
         if (k < wlog.size()) check({nm, "_slice"}, wlog[k], w[WIDTH-1-k*OUT_W -: OUT_W]);
   endtask

   function automatic void add(input bit iv, input logic [WIDTH-1:0] d, input bit f,
                               input bit ew, input logic [OUT_W-1:0] ewd, input bit eb);
      tbl.push_back(vec_t'{iv, d, f, ew, ewd, eb});
   endfunction

   task automatic run_table(input string nm);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(1'b1, tbl[i].iv, tbl[i].d, tbl[i].f);
         check({nm, "_winc"}, fifo_winc, tbl[i].ew);
         if (tbl[i].ew) check({nm, "_wdata"}, fifo_wdata, tbl[i].ewd);
         check({nm, "_busy"}, busy, tbl[i].eb);
         tick();
      end
      tbl.delete();
   endtask

   initial begin
      bit               iv_r;
      bit               f_r;
      bit               r_r;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      fifo_full = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      drive(1'b1, 1'b0, '0, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_winc", fifo_winc, 1'b0);
      check("rst_wdata", fifo_wdata, '0);
      check("rst_overrun", overrun, 1'b0);
      tick();

      // basic word: busy for exactly 5 cycles
      add(1, 32'hA1B2C3D4, 0, 0, 8'h00, 0);
      add(1, 32'hA1B2C3D4, 0, 1, 8'hA1, 1);
      add(0, 32'h0,        0, 1, 8'hB2, 1);
      add(0, 32'h0,        0, 1, 8'hC3, 1);
      add(0, 32'h0,        0, 1, 8'hD4, 1);
      add(0, 32'h0,        0, 0, 8'h00, 1);
      add(0, 32'h0,        0, 0, 8'h00, 0);
      run_table("basic");

      // backpressure from the second slice for 3 cycles
      add(1, 32'hA1B2C3D4, 0, 0, 8'h00, 0);
      add(1, 32'hA1B2C3D4, 0, 1, 8'hA1, 1);
      add(0, 32'h0,        1, 0, 8'h00, 1);
      add(0, 32'h0,        1, 0, 8'h00, 1);
      add(0, 32'h0,        1, 0, 8'h00, 1);
      add(0, 32'h0,        0, 1, 8'hB2, 1);
      add(0, 32'h0,        0, 1, 8'hC3, 1);
      add(0, 32'h0,        1, 0, 8'h00, 1);
      add(0, 32'h0,        0, 1, 8'hD4, 1);
      add(0, 32'h0,        0, 0, 8'h00, 1);
      add(0, 32'h0,        0, 0, 8'h00, 0);
      run_table("bp");

      // held valid
      wlog.delete();
      for (int i = 0; i < 11; i++) cyc(1'b1, 1'b1, 32'h55667788, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check("held_busy_at_fall", busy, 1'b1);
      tick();
      drive(1'b1, 1'b0, '0, 1'b0);
      check("held_busy_after", busy, 1'b0);
      tick();
      check_log("held", 32'h55667788);

      // overrun during EMIT
      wlog.delete();
      cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 32'h11223344, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check_log("ovr", 32'hDEADBEEF);
      check("ovr_sticky", overrun, 1'b1);

      // reset after two slices
      wlog.delete();
      cyc(1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, '0, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_winc", fifo_winc, 1'b0);
      check("mrst_overrun", overrun, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check("mrst_writes", wlog.size(), 2);
      wlog.delete();
      cyc(1'b1, 1'b1, 32'h0F1E2D3C, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check_log("mrst_next", 32'h0F1E2D3C);

`ifdef HS_RX_UNPACKER_WCNT_EN
      force dut.word_cnt = 16'hFFFF;
      #1;
      release dut.word_cnt;
      m_cnt = 16'hFFFF;
      cyc(1'b1, 1'b1, 32'h01020304, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      check("cnt_wrap", word_cnt, 16'h0000);
`endif

      // randomized traffic against the model
      iv_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) iv_r = ~iv_r;
         f_r = ($urandom_range(0, 9) < 3);
         r_r = ($urandom_range(0, 199) != 0);
         cyc(r_r, iv_r, $urandom, f_r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
